// File: rtl/splitter_pkg.sv
// splitter_pkg
//   Shared definitions for the sample splitter family.
//   sched_state_e  : burst scheduler states (IDLE, ACTIVE, GAP)
//   SAMPLE_W/HALF_W: default sample width and the width of each output half
//   DEF_ACTIVE_SAMPLES / DEF_IDLE_SAMPLES: legacy fixed schedule, used as the
//   power-on contents of the scheduler's length shadow registers.
package splitter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } sched_state_e;

  localparam int SAMPLE_W           = 64;
  localparam int HALF_W             = SAMPLE_W / 2;
  localparam int DEF_ACTIVE_SAMPLES = 3276;
  localparam int DEF_IDLE_SAMPLES   = 1176;

endpackage

// File: rtl/splitter_out_stage.sv
// splitter_out_stage
//   Single-slot valid/ready output register that splits one sample into an
//   upper and a lower half presented on two ports with a shared valid.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     accept       : load sample_in into the slot this cycle
//     sample_in    : SAMPLE_W-bit sample
//     port_ready   : common downstream ready
//     slot_free    : slot can take a new sample this cycle
//     port1_data   : sample[SAMPLE_W-1:SAMPLE_W/2]
//     port2_data   : sample[SAMPLE_W/2-1:0]
//     port_valid   : common valid for both ports
module splitter_out_stage #(
  parameter int SAMPLE_W = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  accept,
  input  logic [SAMPLE_W-1:0]   sample_in,
  input  logic                  port_ready,
  output logic                  slot_free,
  output logic [SAMPLE_W/2-1:0] port1_data,
  output logic [SAMPLE_W/2-1:0] port2_data,
  output logic                  port_valid
);
  import splitter_pkg::*;

  localparam int H = SAMPLE_W / 2;

  logic [H-1:0] port1_reg;
  logic [H-1:0] port2_reg;
  logic         valid_reg;

  // The slot is reusable in the same cycle its current content is taken.
  assign slot_free = !valid_reg || port_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port1_reg <= '0;
      port2_reg <= '0;
      valid_reg <= 1'b0;
    end else if (accept) begin
      port1_reg <= sample_in[SAMPLE_W-1:H];
      port2_reg <= sample_in[H-1:0];
      valid_reg <= 1'b1;
    end else if (port_ready) begin
      // Data is left in place; only valid drops when the slot drains.
      valid_reg <= 1'b0;
    end
  end

  assign port1_data = port1_reg;
  assign port2_data = port2_reg;
  assign port_valid = valid_reg;

endmodule

// File: rtl/splitter_burst_scheduler.sv
// splitter_burst_scheduler
//   Groups samples from a valid/ready source into bursts of cfg_active_len
//   accepted samples separated by cfg_gap_len idle cycles, and splits each
//   sample onto two half-width ports through a single-slot output register.
//   Ports:
//     clk, rst_n       : clock, asynchronous active-low reset
//     cfg_active_len   : samples per burst (0 rejected at start)
//     cfg_gap_len      : idle cycles between bursts (0 = back-to-back)
//     cfg_num_bursts   : bursts per run (0 = until stop)
//     start, stop      : single-cycle run control pulses
//     sample_valid/sample_in/slave_ready : upstream handshake
//     port1_data/port2_data/port_valid/port_ready : downstream handshake
//     busy, done       : run in progress / one-cycle end-of-run pulse
//     burst_cnt        : bursts completed in the current run
//     underflow_cnt    : saturating count of starved ACTIVE cycles
module splitter_burst_scheduler #(
  parameter int SAMPLE_W   = 64,
  parameter int LEN_W      = 16,
  parameter int DEF_ACTIVE = 3276,
  parameter int DEF_GAP    = 1176
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LEN_W-1:0]      cfg_active_len,
  input  logic [LEN_W-1:0]      cfg_gap_len,
  input  logic [LEN_W-1:0]      cfg_num_bursts,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  sample_valid,
  input  logic [SAMPLE_W-1:0]   sample_in,
  output logic                  slave_ready,
  output logic [SAMPLE_W/2-1:0] port1_data,
  output logic [SAMPLE_W/2-1:0] port2_data,
  output logic                  port_valid,
  input  logic                  port_ready,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_W-1:0]      burst_cnt,
  output logic [LEN_W-1:0]      underflow_cnt
);
  import splitter_pkg::*;

  sched_state_e state_reg, state_next;

  logic [LEN_W-1:0] active_len_reg;
  logic [LEN_W-1:0] gap_len_reg;
  logic [LEN_W-1:0] num_bursts_reg;
  logic [LEN_W-1:0] beat_reg;
  logic [LEN_W-1:0] gap_cnt_reg;
  logic [LEN_W-1:0] burst_cnt_reg;
  logic [LEN_W-1:0] underflow_reg;
  logic             stop_pending_reg;
  logic             busy_d_reg;
  logic             done_reg;

  logic             slot_free;
  logic             accept;
  logic             start_ok;
  logic             last_beat;
  logic             run_limit;
  logic             stop_eff;
  logic             gap_end;
  logic             starved;
  logic [LEN_W-1:0] burst_cnt_inc;

  splitter_out_stage #(
    .SAMPLE_W (SAMPLE_W)
  ) u_out_stage (
    .clk        (clk),
    .rst_n      (rst_n),
    .accept     (accept),
    .sample_in  (sample_in),
    .port_ready (port_ready),
    .slot_free  (slot_free),
    .port1_data (port1_data),
    .port2_data (port2_data),
    .port_valid (port_valid)
  );

  assign slave_ready   = (state_reg == ACTIVE) && slot_free;
  assign accept        = sample_valid && slave_ready;
  assign start_ok      = (state_reg == IDLE) && start && (cfg_active_len != '0);
  assign last_beat     = accept && (beat_reg == active_len_reg - LEN_W'(1));
  assign burst_cnt_inc = burst_cnt_reg + LEN_W'(1);
  assign run_limit     = (num_bursts_reg != '0) && (burst_cnt_inc == num_bursts_reg);
  // A stop arriving together with the final accept still ends the run.
  assign stop_eff      = stop_pending_reg || stop;
  assign gap_end       = (gap_cnt_reg == gap_len_reg - LEN_W'(1));
  assign starved       = (state_reg == ACTIVE) && slot_free && !sample_valid;
  assign busy          = (state_reg != IDLE) || port_valid;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_ok) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (last_beat) begin
          if (stop_eff || run_limit)  state_next = IDLE;
          else if (gap_len_reg == '0) state_next = ACTIVE;
          else                        state_next = GAP;
        end
      end
      GAP: begin
        if (stop_eff)     state_next = IDLE;
        else if (gap_end) state_next = ACTIVE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Run configuration is captured once per start so mid-run cfg changes
  // cannot disturb the schedule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_len_reg <= LEN_W'(DEF_ACTIVE);
      gap_len_reg    <= LEN_W'(DEF_GAP);
      num_bursts_reg <= '0;
    end else if (start_ok) begin
      active_len_reg <= cfg_active_len;
      gap_len_reg    <= cfg_gap_len;
      num_bursts_reg <= cfg_num_bursts;
    end
  end

  // Beats count accepts only, so starvation stretches a burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         beat_reg <= '0;
    else if (start_ok)  beat_reg <= '0;
    else if (last_beat) beat_reg <= '0;
    else if (accept)    beat_reg <= beat_reg + LEN_W'(1);
  end

  // Gap counter restarts whenever GAP is entered; backpressure is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 gap_cnt_reg <= '0;
    else if (state_reg != GAP)  gap_cnt_reg <= '0;
    else                        gap_cnt_reg <= gap_cnt_reg + LEN_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt_reg <= '0;
      underflow_reg <= '0;
    end else if (start_ok) begin
      burst_cnt_reg <= '0;
      underflow_reg <= '0;
    end else begin
      if (last_beat) burst_cnt_reg <= burst_cnt_inc;
      if (starved && (underflow_reg != {LEN_W{1'b1}}))
        underflow_reg <= underflow_reg + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              stop_pending_reg <= 1'b0;
    else if (state_next == IDLE)             stop_pending_reg <= 1'b0;
    else if (stop && (state_reg != IDLE))    stop_pending_reg <= 1'b1;
  end

  // done is raised in the cycle following the first cycle with busy low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_d_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      busy_d_reg <= busy;
      done_reg   <= busy_d_reg && !busy;
    end
  end

  assign done          = done_reg;
  assign burst_cnt     = burst_cnt_reg;
  assign underflow_cnt = underflow_reg;

endmodule

// File: tb/tb_splitter_burst_scheduler.sv
// tb_splitter_burst_scheduler
//   Directed bench: each step drives the scheduler and compares outputs with
//   hand-derived values through immediate assertions.
module tb_splitter_burst_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cfg_active_len, cfg_gap_len, cfg_num_bursts;
  logic        start, stop, sample_valid, port_ready;
  logic [63:0] sample_in;
  logic        slave_ready, port_valid, busy, done;
  logic [31:0] port1_data, port2_data;
  logic [15:0] burst_cnt, underflow_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Monitor state (written only by the monitor process)
  int          acc_total = 0;
  int          rx_n = 0;
  int          done_cnt = 0;
  int          stab_viol = 0;
  int          sr_viol = 0;
  logic [63:0] rx_mem [0:255];
  logic        hold_flag = 1'b0;
  logic [63:0] held_data = '0;

  // Marks (written only by the stimulus process)
  int          acc_base = 0;
  int          rx_mark = 0;
  int          done_mark = 0;
  logic [63:0] src_base = 64'h1111_2222_3333_4444;
  int          idx;
  logic [11:0] sr_bits;

  always #5 clk = ~clk;

  assign idx       = acc_total - acc_base;
  assign sample_in = src_base + {32'(idx), 32'(idx)};

  splitter_burst_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_active_len (cfg_active_len),
    .cfg_gap_len    (cfg_gap_len),
    .cfg_num_bursts (cfg_num_bursts),
    .start          (start),
    .stop           (stop),
    .sample_valid   (sample_valid),
    .sample_in      (sample_in),
    .slave_ready    (slave_ready),
    .port1_data     (port1_data),
    .port2_data     (port2_data),
    .port_valid     (port_valid),
    .port_ready     (port_ready),
    .busy           (busy),
    .done           (done),
    .burst_cnt      (burst_cnt),
    .underflow_cnt  (underflow_cnt)
  );

  always @(posedge clk) begin
    if (sample_valid && slave_ready) acc_total <= acc_total + 1;
    if (port_valid && port_ready) begin
      rx_mem[rx_n % 256] <= {port1_data, port2_data};
      rx_n <= rx_n + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (hold_flag && rst_n && (port_valid !== 1'b1 || {port1_data, port2_data} !== held_data))
      stab_viol <= stab_viol + 1;
    if (port_valid && !port_ready && slave_ready) sr_viol <= sr_viol + 1;
    hold_flag <= port_valid && !port_ready;
    held_data <= {port1_data, port2_data};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the first negedge of the run.
  task automatic start_run(input int a, input int g, input int b);
    acc_base       = acc_total;
    rx_mark        = rx_n;
    done_mark      = done_cnt;
    cfg_active_len = 16'(a);
    cfg_gap_len    = 16'(g);
    cfg_num_bursts = 16'(b);
    start          = 1'b1;
    @(negedge clk);
    start          = 1'b0;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge clk);
    check(tag, {63'd0, busy}, 64'd0);
    tick(2);
  endtask

  task automatic check_rx(input string tag, input int count);
    check({tag, "_count"}, 64'(rx_n - rx_mark), 64'(count));
    for (int k = 0; k < count; k++)
      check({tag, "_data"}, rx_mem[(rx_mark + k) % 256], src_base + {32'(k), 32'(k)});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; sample_valid = 1'b0; port_ready = 1'b1;
    cfg_active_len = '0; cfg_gap_len = '0; cfg_num_bursts = '0;
    tick(2);
    // Reset state
    check("rst_port_valid", {63'd0, port_valid}, 64'd0);
    check("rst_port_data", {port1_data, port2_data}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_slave_ready", {63'd0, slave_ready}, 64'd0);
    check("rst_counts", {32'd0, burst_cnt, underflow_cnt}, 64'd0);
    rst_n = 1'b1;
    tick(1);

    // Basic burst: 4 beats, 3 gap cycles, 4 beats, IDLE
    sample_valid = 1'b1;
    start_run(4, 3, 2);
    #1;
    check("basic_port_valid_first", {63'd0, port_valid}, 64'd0);
    for (int i = 0; i < 12; i++) begin
      sr_bits = {sr_bits[10:0], slave_ready};
      if (i == 1) check("basic_port1", 64'(port1_data), 64'h1111_2222);
      if (i == 1) check("basic_port2", 64'(port2_data), 64'h3333_4444);
      @(negedge clk);
    end
    check("basic_sr_pattern", 64'(sr_bits), 64'(12'b1111_0001_1110));
    run_until_idle("basic_idle", 50);
    check("basic_burst_cnt", 64'(burst_cnt), 64'd2);
    check("basic_done", 64'(done_cnt - done_mark), 64'd1);
    check_rx("basic_rx", 8);

    // Backpressure: port_ready toggling, 6 samples in order, held while stalled
    start_run(6, 0, 1);
    for (int i = 0; i < 100 && busy; i++) begin
      port_ready = i[0];
      @(negedge clk);
    end
    port_ready = 1'b1;
    run_until_idle("bp_idle", 20);
    check_rx("bp_rx", 6);
    check("bp_stable", 64'(stab_viol), 64'd0);
    check("bp_sr_stall", 64'(sr_viol), 64'd0);

    // Starvation: 5 starved cycles after two accepts
    start_run(4, 0, 1);
    tick(2);
    sample_valid = 1'b0;
    tick(5);
    sample_valid = 1'b1;
    run_until_idle("starve_idle", 30);
    check("starve_underflow", 64'(underflow_cnt), 64'd5);
    check_rx("starve_rx", 4);
    check("starve_burst_cnt", 64'(burst_cnt), 64'd1);

    // Continuous mode, stop at beat 2: burst completes, then IDLE without GAP
    start_run(4, 5, 0);
    tick(2);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    tick(2);
    #1;
    check("stop_busy_low", {63'd0, busy}, 64'd0);
    run_until_idle("stop_idle", 20);
    check_rx("stop_rx", 4);
    check("stop_burst_cnt", 64'(burst_cnt), 64'd1);
    check("stop_done", 64'(done_cnt - done_mark), 64'd1);

    // Stop during GAP: IDLE on the next cycle
    start_run(2, 6, 0);
    tick(2);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    #1;
    check("gapstop_busy_low", {63'd0, busy}, 64'd0);
    check("gapstop_burst_cnt", 64'(burst_cnt), 64'd1);
    tick(2);
    check("gapstop_done", 64'(done_cnt - done_mark), 64'd1);

    // Gap 0: three back-to-back bursts of 2
    start_run(2, 0, 3);
    sr_bits = '0;
    for (int i = 0; i < 7; i++) begin
      sr_bits = {sr_bits[10:0], slave_ready};
      @(negedge clk);
    end
    check("gap0_sr_pattern", 64'(sr_bits[6:0]), 64'(7'b111_1110));
    run_until_idle("gap0_idle", 20);
    check_rx("gap0_rx", 6);
    check("gap0_burst_cnt", 64'(burst_cnt), 64'd3);

    // active=0 start ignored
    start_run(0, 2, 1);
    #1;
    check("zero_busy", {63'd0, busy}, 64'd0);
    check("zero_slave_ready", {63'd0, slave_ready}, 64'd0);
    check("zero_burst_cnt", 64'(burst_cnt), 64'd3);

    // Reset mid-burst, then a clean run
    tick(1);
    start_run(4, 0, 1);
    tick(2);
    rst_n = 1'b0;
    #1;
    check("midrst_port_valid", {63'd0, port_valid}, 64'd0);
    check("midrst_port_data", {port1_data, port2_data}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_burst_cnt", 64'(burst_cnt), 64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("midrst_no_done", 64'(done_cnt - done_mark), 64'd0);
    start_run(4, 0, 1);
    run_until_idle("rerun_idle", 30);
    check_rx("rerun_rx", 4);
    check("rerun_burst_cnt", 64'(burst_cnt), 64'd1);
    check("rerun_done", 64'(done_cnt - done_mark), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
